// File: rtl/pic_inta_sequencer_if.sv
// Bus-side signal bundle of the INTA responder. The master modport is the sequencer.
// The slave modport is the surrounding resolver, CPU and bus buffer.
interface pic_inta_sequencer_if;
  logic       inta;
  logic       intValid;
  logic [2:0] intLevel;
  logic [2:0] casIn;
  logic [2:0] casOut;
  logic       casOE;
  logic [7:0] DBusOut;
  logic       DBusOE;
  logic       freeze;
  logic       setISR;
  logic       clearIRR;
  logic       aeoiPulse;
  logic [2:0] ackLevel;

  modport master (
    input  inta, intValid, intLevel, casIn,
    output casOut, casOE, DBusOut, DBusOE, freeze, setISR, clearIRR, aeoiPulse, ackLevel
  );

  modport slave (
    output inta, intValid, intLevel, casIn,
    input  casOut, casOE, DBusOut, DBusOE, freeze, setISR, clearIRR, aeoiPulse, ackLevel
  );
endinterface

// File: rtl/pic_inta_sequencer.sv
// 8259A INTA responder: sequences INTA pulses, commands ISR/IRR updates, drives vector bytes and CAS.
// Define MODE_8080_EN to build the 8080 three-pulse CALL sequence (uPM, ADI, vecLow, vecHigh).
module pic_inta_sequencer #(
  parameter logic [2:0] SPUR_LEVEL = 3'd7
) (
  input  logic                        clk,
  input  logic                        reset,
  pic_inta_sequencer_if.master        bus,
  input  logic [4:0]                  TReg,
  input  logic                        SNGL,
  input  logic                        MS,
  input  logic [7:0]                  SReg,
  input  logic                        AEOI,
  input  logic                        uPM,
  input  logic                        ADI,
  input  logic [2:0]                  vecLow,
  input  logic [7:0]                  vecHigh
);

`ifdef MODE_8080_EN
  typedef enum logic [2:0] {S_IDLE, S_P1, S_W1, S_P2, S_W2, S_P3} state_t;
  logic mode_8080;
  assign mode_8080 = ~uPM;
`else
  typedef enum logic [1:0] {S_IDLE, S_P1, S_W1, S_P2} state_t;
  logic unused_cfg;
  assign unused_cfg = &{1'b0, uPM, ADI, vecLow, vecHigh};
`endif

  state_t     state_q, state_d;
  logic       inta_q;
  logic [2:0] ack_q, ack_d;
  logic       spur_q, spur_d;
  logic       set_q, set_d;
  logic       aeoi_q, aeoi_d;
  logic       freeze_q;
  logic       cas_oe_q, cas_oe_d;
  logic [2:0] cas_q;
  logic       dbus_oe_q, dbus_oe_d;
  logic [7:0] dbus_q, dbus_d;
  logic       vec_ok;
  logic       rise, fall;

  assign rise = bus.inta & ~inta_q;
  assign fall = ~bus.inta & inta_q;

  always_comb begin
    // NOTE: every combinational output is defaulted first so no branch can leave it unassigned (no latches).
    state_d = state_q;
    ack_d   = ack_q;
    spur_d  = spur_q;
    set_d   = 1'b0;
    aeoi_d  = 1'b0;

    // Rises in P states and falls in W/IDLE states are ignored by construction.
    case (state_q)
      S_IDLE: if (rise) begin
        state_d = S_P1;
        ack_d   = bus.intValid ? bus.intLevel : SPUR_LEVEL;
        spur_d  = ~bus.intValid;
        set_d   = bus.intValid;
      end
      S_P1: if (fall) state_d = S_W1;
      S_W1: if (rise) state_d = S_P2;
      S_P2: if (fall) begin
        state_d = S_IDLE;
        aeoi_d  = AEOI & ~spur_q;
`ifdef MODE_8080_EN
        if (mode_8080) begin
          state_d = S_W2;
          aeoi_d  = 1'b0;
        end
`endif
      end
`ifdef MODE_8080_EN
      S_W2: if (rise) state_d = S_P3;
      S_P3: if (fall) begin
        state_d = S_IDLE;
        aeoi_d  = AEOI & ~spur_q;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Vector bytes go out only from the single PIC, a master owning the level, or the addressed slave.
    vec_ok   = SNGL | (MS ? ~SReg[ack_d] : (bus.casIn == SReg[2:0]));
    cas_oe_d = (state_d != S_IDLE) & ~SNGL & MS & SReg[ack_d];

    dbus_oe_d = 1'b0;
    dbus_d    = 8'h00;
    case (state_d)
      S_P1: begin
`ifdef MODE_8080_EN
        if (mode_8080 && (SNGL || MS)) begin
          dbus_oe_d = 1'b1;
          dbus_d    = 8'hCD;
        end
`endif
      end
      S_P2: if (vec_ok) begin
        dbus_oe_d = 1'b1;
        dbus_d    = {TReg, ack_d};
`ifdef MODE_8080_EN
        if (mode_8080)
          dbus_d = ADI ? {vecLow, ack_d, 2'b00} : {vecLow[2:1], ack_d, 3'b000};
`endif
      end
`ifdef MODE_8080_EN
      S_P3: if (vec_ok) begin
        dbus_oe_d = 1'b1;
        dbus_d    = vecHigh;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q   <= S_IDLE;
      inta_q    <= 1'b0;
      ack_q     <= 3'd0;
      spur_q    <= 1'b0;
      set_q     <= 1'b0;
      aeoi_q    <= 1'b0;
      freeze_q  <= 1'b0;
      cas_oe_q  <= 1'b0;
      cas_q     <= 3'd0;
      dbus_oe_q <= 1'b0;
      dbus_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      inta_q    <= bus.inta;
      ack_q     <= ack_d;
      spur_q    <= spur_d;
      set_q     <= set_d;
      aeoi_q    <= aeoi_d;
      freeze_q  <= (state_d != S_IDLE);
      cas_oe_q  <= cas_oe_d;
      cas_q     <= cas_oe_d ? ack_d : 3'd0;
      dbus_oe_q <= dbus_oe_d;
      dbus_q    <= dbus_d;
    end
  end

  assign bus.freeze    = freeze_q;
  assign bus.setISR    = set_q;
  assign bus.clearIRR  = set_q;
  assign bus.aeoiPulse = aeoi_q;
  assign bus.ackLevel  = ack_q;
  assign bus.casOE     = cas_oe_q;
  assign bus.casOut    = cas_q;
  assign bus.DBusOE    = dbus_oe_q;
  assign bus.DBusOut   = dbus_q;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Scoreboard bench for pic_inta_sequencer: stimulus pushes expected per-phase snapshots and pulses,
// a monitor pops them when inta has settled or a command pulse appears.
module tb_pic_inta_sequencer;

  typedef struct packed {
    logic       freeze;
    logic       dbus_oe;
    logic [7:0] dbus;
    logic       cas_oe;
    logic [2:0] cas;
    logic [2:0] ack;
  } snap_t;

  typedef struct packed {
    logic       set_isr;
    logic       clear_irr;
    logic       aeoi;
    logic [2:0] ack;
  } pulse_t;

  typedef struct packed {
    logic       sngl;
    logic       ms;
    logic [7:0] sreg;
    logic [2:0] cas_in;
    logic       valid;
    logic [2:0] level;
    logic [4:0] treg;
    logic       aeoi;
    logic       upm;
    logic       adi;
    logic [2:0] vec_low;
    logic [7:0] vec_high;
  } cfg_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] treg;
  logic       sngl, ms, aeoi, upm, adi;
  logic [7:0] sreg, vec_high;
  logic [2:0] vec_low;

  int checks   = 0;
  int failures = 0;
  snap_t  exp_snap[$];
  pulse_t exp_pulse[$];

  always #5 clk = ~clk;

  pic_inta_sequencer_if bus();

  pic_inta_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .TReg    (treg),
    .SNGL    (sngl),
    .MS      (ms),
    .SReg    (sreg),
    .AEOI    (aeoi),
    .uPM     (upm),
    .ADI     (adi),
    .vecLow  (vec_low),
    .vecHigh (vec_high)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic snap_t mk_snap(input logic fr, input logic oe, input logic [7:0] d,
                                    input logic coe, input logic [2:0] ack);
    snap_t s;
    s.freeze  = fr;
    s.dbus_oe = oe;
    s.dbus    = oe ? d : 8'h00;
    s.cas_oe  = coe;
    s.cas     = coe ? ack : 3'd0;
    s.ack     = ack;
    return s;
  endfunction

  function automatic pulse_t mk_pulse(input logic set, input logic ae, input logic [2:0] ack);
    pulse_t p;
    p.set_isr   = set;
    p.clear_irr = set;
    p.aeoi      = ae;
    p.ack       = ack;
    return p;
  endfunction

  // Monitor: one snapshot per settled inta level, one pop per command pulse cycle.
  initial begin
    logic   prev;
    int     stable;
    snap_t  act_s;
    pulse_t act_p;
    prev   = 1'b0;
    stable = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stable = 0;
        prev   = bus.inta;
      end else begin
        if (bus.inta !== prev) stable = 0;
        else stable++;
        prev = bus.inta;
        if (stable == 2) begin
          act_s = {bus.freeze, bus.DBusOE, bus.DBusOut, bus.casOE, bus.casOut, bus.ackLevel};
          if (exp_snap.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL snapshot_unexpected: got 0x%0h expected none at %0t", act_s, $time);
          end else
            check("snapshot", 32'(act_s), 32'(exp_snap.pop_front()));
        end
        if (bus.setISR || bus.clearIRR || bus.aeoiPulse) begin
          act_p = {bus.setISR, bus.clearIRR, bus.aeoiPulse, bus.ackLevel};
          if (exp_pulse.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pulse_unexpected: got 0x%0h expected none at %0t", act_p, $time);
          end else
            check("pulse", 32'(act_p), 32'(exp_pulse.pop_front()));
        end
      end
    end
  end

  task automatic hold_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold();
    hold_n($urandom_range(3, 5));
  endtask

  function automatic cfg_t base_cfg();
    cfg_t c;
    c = '0;
    c.sngl  = 1'b1;
    c.treg  = 5'b11001;
    c.valid = 1'b1;
    c.level = 3'd3;
    c.upm   = 1'b1;
    return c;
  endfunction

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.sngl     = 1'($urandom);
    c.ms       = 1'($urandom);
    c.sreg     = 8'($urandom);
    c.cas_in   = ($urandom_range(0, 1) == 1) ? c.sreg[2:0] : 3'($urandom);
    c.valid    = ($urandom_range(0, 3) != 0);
    c.level    = 3'($urandom);
    c.treg     = 5'($urandom);
    c.aeoi     = 1'($urandom);
    c.upm      = 1'($urandom);
    c.adi      = 1'($urandom);
    c.vec_low  = 3'($urandom);
    c.vec_high = 8'($urandom);
    return c;
  endfunction

  // Reference: the acknowledged level, the bytes of the CALL/vector sequence and who may drive them.
  task automatic run_seq(input cfg_t c, input bit reset_in_w1);
    bit         m8080, coe, ok;
    logic [2:0] lvl;
    logic [7:0] b2;
    treg = c.treg; sngl = c.sngl; ms = c.ms; sreg = c.sreg; aeoi = c.aeoi;
    upm = c.upm; adi = c.adi; vec_low = c.vec_low; vec_high = c.vec_high;
    bus.casIn = c.cas_in; bus.intValid = c.valid; bus.intLevel = c.level;
`ifdef MODE_8080_EN
    m8080 = !c.upm;
`else
    m8080 = 1'b0;
`endif
    lvl = c.valid ? c.level : 3'd7;
    coe = !c.sngl && c.ms && c.sreg[lvl];
    ok  = c.sngl || (c.ms ? !c.sreg[lvl] : (c.cas_in == c.sreg[2:0]));
    if (!m8080)    b2 = {c.treg, lvl};
    else if (c.adi) b2 = {c.vec_low, lvl, 2'b00};
    else            b2 = {c.vec_low[2:1], lvl, 3'b000};

    exp_snap.push_back(mk_snap(1'b1, m8080 && (c.sngl || c.ms), 8'hCD, coe, lvl));
    if (c.valid) exp_pulse.push_back(mk_pulse(1'b1, 1'b0, lvl));
    bus.inta = 1'b1;
    hold();
    // Resolver output wanders after P1; the latched level must not follow it.
    bus.intValid = 1'($urandom);
    bus.intLevel = 3'($urandom);
    exp_snap.push_back(mk_snap(1'b1, 1'b0, 8'h00, coe, lvl));
    bus.inta = 1'b0;
    if (reset_in_w1) begin
      hold_n(3);
      exp_snap.push_back(mk_snap(1'b0, 1'b0, 8'h00, 1'b0, 3'd0));
      reset = 1'b1;
      hold_n(2);
      reset = 1'b0;
      hold_n(4);
      return;
    end
    hold();
    exp_snap.push_back(mk_snap(1'b1, ok, b2, coe, lvl));
    bus.inta = 1'b1;
    hold();
    if (m8080) begin
      exp_snap.push_back(mk_snap(1'b1, 1'b0, 8'h00, coe, lvl));
      bus.inta = 1'b0;
      hold();
      exp_snap.push_back(mk_snap(1'b1, ok, c.vec_high, coe, lvl));
      bus.inta = 1'b1;
      hold();
    end
    exp_snap.push_back(mk_snap(1'b0, 1'b0, 8'h00, 1'b0, lvl));
    if (c.aeoi && c.valid) exp_pulse.push_back(mk_pulse(1'b0, 1'b1, lvl));
    bus.inta = 1'b0;
    hold();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cfg_t c;
    reset = 1'b1;
    bus.inta = 1'b0; bus.intValid = 1'b0; bus.intLevel = 3'd0; bus.casIn = 3'd0;
    treg = '0; sngl = 1'b0; ms = 1'b0; sreg = '0; aeoi = 1'b0;
    upm = 1'b1; adi = 1'b0; vec_low = '0; vec_high = '0;
    exp_snap.push_back(mk_snap(1'b0, 1'b0, 8'h00, 1'b0, 3'd0));
    @(posedge clk); #1;
    hold_n(3);
    reset = 1'b0;
    hold_n(4);

    c = base_cfg();                     run_seq(c, 1'b0);
    c.aeoi = 1'b1;                      run_seq(c, 1'b0);
    c.valid = 1'b0;                     run_seq(c, 1'b0);
    c = base_cfg(); c.sngl = 1'b0; c.ms = 1'b1; c.sreg = 8'h04; c.level = 3'd2;
    run_seq(c, 1'b0);
    c.sreg = 8'h00;                     run_seq(c, 1'b0);
    c = base_cfg(); c.sngl = 1'b0; c.ms = 1'b0; c.sreg = 8'h02; c.cas_in = 3'd2;
    run_seq(c, 1'b0);
    c.cas_in = 3'd5;                    run_seq(c, 1'b0);
    c = base_cfg();                     run_seq(c, 1'b1);
                                        run_seq(c, 1'b0);
`ifdef MODE_8080_EN
    c = base_cfg(); c.upm = 1'b0; c.adi = 1'b1; c.vec_low = 3'b101; c.vec_high = 8'h20; c.level = 3'd6;
    run_seq(c, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      c = rand_cfg();
      run_seq(c, ($urandom_range(0, 9) == 0));
    end

    hold_n(5);
    check("snap_queue_drained", 32'(exp_snap.size()), 32'd0);
    check("pulse_queue_drained", 32'(exp_pulse.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
